ray_scan_generator: RTL and testbench
=====================================

# ray_scan_generator

Generates one primary-ray direction per screen pixel in raster order and drives the `pixel` input of the ray-trace core directly upstream of it. It carries each pixel's screen address and a valid flag through a delay line matched to the core's fixed latency, so the framebuffer writer sees `res_valid`, `res_col` and `res_row` in the same cycle as the core's `less_than_zero` for that pixel. Throughput is one pixel per cycle, gated by downstream `ready`.

## Interface
- `H_RES`, default 640: pixels per row.
- `V_RES`, default 480: rows per frame.
- `FOCAL_Z`, default 31: constant ray z component.
- `CORE_LATENCY`, default 5: cycles from the core sampling `pixel` to its `less_than_zero` update.
- One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `ready`  in  1  downstream can take another issue this cycle.
- `pixel`  out  Pixel_s  ray direction to the core.
- `issue_valid`  out  1  `pixel` holds a new ray this cycle.
- `res_valid`  out  1  core `less_than_zero` belongs to a real pixel this cycle.
- `res_col`  out  $clog2(H_RES)  column of that result.
- `res_row`  out  $clog2(V_RES)  row of that result.
- `res_last`  out  1  result is the frame's final pixel.
- `busy`  out  1  frame in progress (SCAN or DRAIN).
- `frame_done`  out  1  one-cycle pulse after the last result has been delivered.

## Operation
- FSM states:
  - IDLE: `start`=1 → SCAN. On the same edge, load pixel (0,0) with `issue_valid`=1. `start` is ignored in every other state.
  - SCAN: on an edge with `ready`=1, issue the current (col,row) and advance.
    - col wraps from H_RES-1 to 0 and row increments.
    - Issuing (H_RES-1, V_RES-1) → DRAIN.
  - SCAN with `ready`=0: `issue_valid`=0 next cycle, `pixel` held, counters unchanged.
  - DRAIN: count down from CORE_LATENCY. At zero → IDLE and pulse `frame_done`.
- Direction mapping:
  - `pixel.x` = col − H_RES/2 (signed, −320…319).
  - `pixel.y` = V_RES/2 − row (240…−239).
  - `pixel.z` = FOCAL_Z.
  - These give the core's maximum squares: 102400, 57600, 961.
- Delay line: shift register CORE_LATENCY deep holding {valid, col, row, last}.
  - Shifts every cycle unconditionally, because the core has no stall.
  - Input is {`issue_valid`, issued col, issued row, issued-is-last}.
- `ready` throttles new issues only. In-flight results still emerge, so downstream must absorb up to CORE_LATENCY results after dropping `ready`.
- Reset mid-frame: state → IDLE, counters 0, all delay-line valid bits cleared. No `res_valid` or `frame_done` emerges for the aborted frame.
- Reset values: `pixel` = {−H_RES/2, V_RES/2, FOCAL_Z}; `issue_valid`, `res_valid`, `res_last`, `busy`, `frame_done` = 0; `res_col`, `res_row` = 0.

## Timing
- `start` high in cycle 0 → `issue_valid` with (0,0) in cycle 1.
- `issue_valid` in cycle c → `res_valid` with the same col/row in cycle c+CORE_LATENCY, coincident with the core's `less_than_zero` for that pixel.
- With `ready` held 1 at defaults:
  - last issue in cycle 307200;
  - `res_last` in cycle 307205;
  - `frame_done` and `busy`=0 in cycle 307206;
  - `busy` high in cycles 1–307205.
- `start` in the `frame_done` cycle is accepted (state is IDLE). The next frame's first issue follows one cycle later.
- `issue_valid` and `res_valid` may both be high in the same cycle; this is the normal steady state.

## Structure
- Pixel_s stays in the shared types package.
- Add to that package: localparam CORE_LATENCY = 5, and a scan-state enum {IDLE, SCAN, DRAIN}.
- Natural sub-module: `valid_delay_line`, parameterised depth and width, resettable valid bit. The top level then holds only the FSM, the counters and the mapping.

## Test plan
- Defaults, `ready`=1, single `start`:
  - first `pixel` = (−320, 240, 31);
  - pixel 641 (col 1, row 1) = (−319, 239, 31);
  - last = (319, −239, 31);
  - `frame_done` exactly in cycle 307206.
- H_RES=4, V_RES=2:
  - `res_col`/`res_row` sequence = 0,0 1,0 2,0 3,0 0,1 … 3,1;
  - each appears exactly 5 cycles after its issue;
  - `res_last` only on (3,1).
- `ready` toggled 1,0,0,1 during SCAN:
  - no pixel skipped or duplicated;
  - `res_valid` has 2-cycle gaps 5 cycles after the stalls.
- `rst` asserted mid-SCAN and mid-DRAIN:
  - all outputs at reset values next cycle;
  - zero `res_valid` afterwards until a new `start`.
- `start` pulsed during SCAN: ignored, frame count unchanged. Back-to-back frames with `start` in the `frame_done` cycle run correctly.
- Scoreboard against the core model with one sphere: per-pixel `less_than_zero` matches the golden discriminant sign at the reported `res_col`/`res_row`.

Source files
------------

// File: rtl/ray_scan_generator_pkg.sv
// Shared types for the primary-ray scan front end.
// Holds the core-facing ray bundle, the core latency and the scan FSM states.
package ray_scan_generator_pkg;

    localparam int COORD_W      = 12;
    localparam int CORE_LATENCY = 5;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } Pixel_s;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } scan_state_e;

endpackage

// File: rtl/ray_scan_generator_valid_delay_line.sv
// Fixed-depth shift register carrying a valid flag plus a data word.
// Ports: clk, rst (sync, active-high), in_valid/in_data -> out_valid/out_data
// DEPTH cycles later. Shifts every cycle; there is no stall input.
module ray_scan_generator_valid_delay_line #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    // Data is cleared too so the address outputs read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/ray_scan_generator.sv
// Raster-order primary-ray generator feeding the ray-trace core, with the
// pixel address delayed to line up with the core's less_than_zero result.
// Ports: clk, rst (sync, active-high), start, ready in; pixel, issue_valid,
// res_valid, res_col, res_row, res_last, busy, frame_done out.
module ray_scan_generator #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int FOCAL_Z      = 31,
    parameter int CORE_LATENCY = ray_scan_generator_pkg::CORE_LATENCY
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          ready,
    output ray_scan_generator_pkg::Pixel_s pixel,
    output logic                          issue_valid,
    output logic                          res_valid,
    output logic [$clog2(H_RES)-1:0]      res_col,
    output logic [$clog2(V_RES)-1:0]      res_row,
    output logic                          res_last,
    output logic                          busy,
    output logic                          frame_done
);

    import ray_scan_generator_pkg::*;

    localparam int CW      = $clog2(H_RES);
    localparam int RW      = $clog2(V_RES);
    localparam int DW      = CW + RW + 1;
    localparam int DRAIN_W = $clog2(CORE_LATENCY + 1);

    localparam logic [CW-1:0] COL_MAX = CW'(H_RES - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(V_RES - 1);

    localparam Pixel_s PIXEL_RST = '{
        x: COORD_W'(0 - H_RES / 2),
        y: COORD_W'(V_RES / 2),
        z: COORD_W'(FOCAL_Z)
    };

    scan_state_e        state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    Pixel_s             pixel_q, pixel_d;
    logic               issue_valid_q, issue_valid_d;
    logic [CW-1:0]      iss_col_q, iss_col_d;
    logic [RW-1:0]      iss_row_q, iss_row_d;
    logic               iss_last_q, iss_last_d;
    logic               frame_done_q, frame_done_d;
    logic               do_issue;
    logic               at_last;

    // Screen-centred direction: x grows right, y grows up.
    function automatic Pixel_s map_dir(
        input logic [CW-1:0] c,
        input logic [RW-1:0] r
    );
        Pixel_s p;
        p.x = COORD_W'(c) - COORD_W'(H_RES / 2);
        p.y = COORD_W'(V_RES / 2) - COORD_W'(r);
        p.z = COORD_W'(FOCAL_Z);
        return p;
    endfunction

    assign at_last = (col_q == COL_MAX) && (row_q == ROW_MAX);

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        drain_d       = drain_q;
        pixel_d       = pixel_q;
        issue_valid_d = 1'b0;
        iss_col_d     = iss_col_q;
        iss_row_d     = iss_row_q;
        iss_last_d    = 1'b0;
        frame_done_d  = 1'b0;
        do_issue      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The (0,0) load on start is not gated by ready.
                if (start) begin
                    state_d  = SCAN;
                    do_issue = 1'b1;
                end
            end
            SCAN: begin
                do_issue = ready;
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_issue) begin
            pixel_d       = map_dir(col_q, row_q);
            issue_valid_d = 1'b1;
            iss_col_d     = col_q;
            iss_row_d     = row_q;
            iss_last_d    = at_last;
            // Both counters wrap on the last pixel so IDLE always sees (0,0).
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (at_last) begin
                state_d = DRAIN;
                drain_d = DRAIN_W'(CORE_LATENCY);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            drain_q       <= '0;
            pixel_q       <= PIXEL_RST;
            issue_valid_q <= 1'b0;
            iss_col_q     <= '0;
            iss_row_q     <= '0;
            iss_last_q    <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            drain_q       <= drain_d;
            pixel_q       <= pixel_d;
            issue_valid_q <= issue_valid_d;
            iss_col_q     <= iss_col_d;
            iss_row_q     <= iss_row_d;
            iss_last_q    <= iss_last_d;
            frame_done_q  <= frame_done_d;
        end
    end

    ray_scan_generator_valid_delay_line #(
        .DEPTH (CORE_LATENCY),
        .WIDTH (DW)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue_valid_q),
        .in_data   ({iss_last_q, iss_row_q, iss_col_q}),
        .out_valid (res_valid),
        .out_data  ({res_last, res_row, res_col})
    );

    assign pixel       = pixel_q;
    assign issue_valid = issue_valid_q;
    assign frame_done  = frame_done_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ray_scan_generator.sv
// Scoreboard bench: a 4x2 generator driving a one-sphere core model, plus a
// default-size generator whose early pixels are checked against fixed values.
module tb_ray_scan_generator;

    import ray_scan_generator_pkg::*;

    localparam int H = 4;
    localparam int V = 2;
    localparam int L = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    Pixel_s     pixel;
    logic       issue_valid, res_valid, res_last, busy, frame_done;
    logic [1:0] res_col;
    logic [0:0] res_row;

    ray_scan_generator #(
        .H_RES(H), .V_RES(V), .FOCAL_Z(31), .CORE_LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .pixel(pixel), .issue_valid(issue_valid),
        .res_valid(res_valid), .res_col(res_col), .res_row(res_row),
        .res_last(res_last), .busy(busy), .frame_done(frame_done)
    );

    logic       rst_b = 1'b1;
    logic       start_b = 1'b0;
    Pixel_s     pixel_b;
    logic       iv_b, rv_b, rl_b, busy_b, fd_b;
    logic [9:0] rc_b;
    logic [8:0] rr_b;

    ray_scan_generator dut_big (
        .clk(clk), .rst(rst_b), .start(start_b), .ready(1'b1),
        .pixel(pixel_b), .issue_valid(iv_b),
        .res_valid(rv_b), .res_col(rc_b), .res_row(rr_b),
        .res_last(rl_b), .busy(busy_b), .frame_done(fd_b)
    );

    // Core model: sphere centre (0,0,62), r^2 = 4; flag set on a miss.
    function automatic logic miss(input int dx, input int dy, input int dz);
        longint cz = 62;
        longint r2 = 4;
        longint b, a;
        b = longint'(dz) * cz;
        a = longint'(dx * dx + dy * dy + dz * dz);
        return (b * b - a * (cz * cz - r2)) < 0;
    endfunction

    logic [L-1:0] core_pipe = '0;
    logic         less_than_zero;
    always @(posedge clk)
        core_pipe <= {core_pipe[L-2:0],
                      miss(int'(pixel.x), int'(pixel.y), int'(pixel.z))};
    assign less_than_zero = core_pipe[L-1];

    typedef struct {int x; int y; int z;} iss_e_t;
    typedef struct {int col; int row; int last; int ltz;} res_e_t;

    iss_e_t exp_iss[$];
    res_e_t exp_res[$];
    int     iss_times[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_n = 0;
    int total_n = 0;
    int exp_frames = 0;
    int frames_seen = 0;
    int timeouts = 0;
    int big_idx = 0;
    int big_hits = 0;
    int due = 0;
    bit armed = 1'b0;
    bit prev_rst = 1'b0;
    bit end_req = 1'b0;
    iss_e_t ei;
    res_e_t er;

    task automatic chk(input string nm, input int act, input int exp_v);
        total_n++;
        if (act == exp_v) pass_n++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endtask

    // Hand-computed hit table, bit index row*4+col, 1 = miss.
    task automatic push_frame();
        logic [7:0] ltz_tab;
        ltz_tab = 8'b0001_1011;
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                exp_iss.push_back('{c - 2, 1 - r, 31});
                exp_res.push_back('{c, r, int'(r == 1 && c == 3),
                                    int'(ltz_tab[r * 4 + c])});
            end
        end
    endtask

    always @(negedge clk) begin
        if (prev_rst) begin
            chk("rst_x", int'(pixel.x), -2);
            chk("rst_y", int'(pixel.y), 1);
            chk("rst_z", int'(pixel.z), 31);
            chk("rst_issue_valid", int'(issue_valid), 0);
            chk("rst_res_valid", int'(res_valid), 0);
            chk("rst_res_last", int'(res_last), 0);
            chk("rst_res_col", int'(res_col), 0);
            chk("rst_res_row", int'(res_row), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_frame_done", int'(frame_done), 0);
            exp_iss.delete();
            exp_res.delete();
            iss_times.delete();
            armed = 1'b0;
        end
        prev_rst = rst;

        if (issue_valid) begin
            if (exp_iss.size() == 0) begin
                chk("issue_unexpected", 1, 0);
            end else begin
                ei = exp_iss.pop_front();
                chk("pix_x", int'(pixel.x), ei.x);
                chk("pix_y", int'(pixel.y), ei.y);
                chk("pix_z", int'(pixel.z), ei.z);
            end
            iss_times.push_back(cyc);
        end

        if (res_valid) begin
            if (exp_res.size() == 0) begin
                chk("res_unexpected", 1, 0);
            end else begin
                er = exp_res.pop_front();
                chk("res_col", int'(res_col), er.col);
                chk("res_row", int'(res_row), er.row);
                chk("res_last", int'(res_last), er.last);
                chk("ltz", int'(less_than_zero), er.ltz);
            end
            if (iss_times.size() == 0) chk("res_no_issue", 1, 0);
            else chk("latency", cyc - iss_times.pop_front(), L);
            chk("busy_res", int'(busy), 1);
            if (res_last) begin
                armed = 1'b1;
                due = cyc + 1;
            end
        end

        if (armed && cyc == due) begin
            chk("frame_done", int'(frame_done), 1);
            chk("busy_done", int'(busy), 0);
            if (frame_done) frames_seen++;
            armed = 1'b0;
        end else if (frame_done) begin
            chk("spurious_done", 1, 0);
        end

        if (!rst_b && iv_b) begin
            if (big_idx == 0) begin
                chk("big0_x", int'(pixel_b.x), -320);
                chk("big0_y", int'(pixel_b.y), 240);
                chk("big0_z", int'(pixel_b.z), 31);
                chk("big0_busy", int'(busy_b), 1);
                big_hits++;
            end
            if (big_idx == 641) begin
                chk("big641_x", int'(pixel_b.x), -319);
                chk("big641_y", int'(pixel_b.y), 239);
                chk("big641_z", int'(pixel_b.z), 31);
                chk("big_res_valid", int'(rv_b), 1);
                chk("big_res_col", int'(rc_b), 636);
                chk("big_res_row", int'(rr_b), 0);
                chk("big_res_last", int'(rl_b), 0);
                chk("big_frame_done", int'(fd_b), 0);
                big_hits++;
            end
            big_idx++;
        end

        if (end_req || cyc > 5000) begin
            if (!end_req) chk("watchdog", 1, 0);
            chk("exp_iss_left", exp_iss.size(), 0);
            chk("exp_res_left", exp_res.size(), 0);
            chk("frames", frames_seen, exp_frames);
            chk("big_hits", big_hits, 2);
            chk("timeouts", timeouts, 0);
            $display("%0d/%0d checks passed", pass_n, total_n);
            $finish;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (frame_done) return;
        end
        timeouts++;
    endtask

    initial begin
        repeat (2) step();
        rst = 1'b0;
        rst_b = 1'b0;
        step();
        step();
        start_b = 1'b1;
        step();
        start_b = 1'b0;

        // Plain frame.
        ready = 1'b1;
        push_frame();
        exp_frames++;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(60);

        // Ready pattern 1,0,0,1 with a stray start during the stall.
        step();
        push_frame();
        exp_frames++;
        start = 1'b1;
        step();
        start = 1'b0;
        ready = 1'b1;
        step();
        ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        ready = 1'b1;
        wait_done(60);

        // Back-to-back: start in the frame_done cycle.
        push_frame();
        exp_frames++;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(60);

        // Reset mid-SCAN.
        step();
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();

        // Reset mid-DRAIN.
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();

        // Recovery frame.
        push_frame();
        exp_frames++;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(60);

        for (int i = 0; i < 1000 && big_hits < 2; i++) step();
        repeat (3) step();
        end_req = 1'b1;
        repeat (5) step();
    end

endmodule
